// File: rtl/fetch_buffer.sv
// Fetch buffer: circular FIFO decoupling the fetch stage from decode.
// Holds {instr, pc} pairs and raises stall one entry early to cover the in-flight fetch.
module fetch_buffer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [XLEN-1:0]            in_instr,
   input  logic [XLEN-1:0]            in_pc,
   output logic                       stall_fetch_o,
   output logic                       out_valid,
   output logic [XLEN-1:0]            out_instr,
   output logic [XLEN-1:0]            out_pc,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            overflow;
   logic            full;
   logic            push;
   logic            pop;
   logic            drop;

   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready && !flush;
   // A full buffer still accepts when the head leaves in the same cycle.
   assign push      = in_valid && !flush && (!full || pop);
   assign drop      = in_valid && !flush && full && !pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop) overflow <= 1'b1;
      end
   end

   // Storage is not reset; pointer and count state alone govern visibility.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         instr_mem[wr_ptr] <= in_instr;
         pc_mem[wr_ptr]    <= in_pc;
      end
   end

   always_comb begin
      out_instr = NOP_INSTR;
      out_pc    = '1;
      if (out_valid) begin
         out_instr = instr_mem[rd_ptr];
         out_pc    = pc_mem[rd_ptr];
      end
   end

   assign stall_fetch_o = (count >= CW'(DEPTH - 1));
   assign count_o       = count;
   assign overflow_o    = overflow;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (XLEN=32, DEPTH=4).
module tb_fetch_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        stall_fetch_o;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic [2:0]  count_o;
   logic        overflow_o;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   fetch_buffer #(.XLEN(32), .DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .stall_fetch_o (stall_fetch_o),
      .out_valid     (out_valid),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .out_ready     (out_ready),
      .count_o       (count_o),
      .overflow_o    (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      in_valid  = v;
      in_instr  = instr;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"},    64'(count_o),       64'd0);
      check({tag, "_valid"},    64'(out_valid),     64'd0);
      check({tag, "_instr"},    64'(out_instr),     64'h13);
      check({tag, "_pc"},       64'(out_pc),        64'hFFFF_FFFF);
      check({tag, "_stall"},    64'(stall_fetch_o), 64'd0);
      check({tag, "_overflow"}, 64'(overflow_o),    64'd0);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b0;
      check_reset_state("rst");

      // Three pushes, decode holding off
      drive(1'b1, 32'hA, 32'h00, 1'b0, 1'b0);
      #1 check("no_bypass_valid", 64'(out_valid), 64'd0);
      step();
      check("push1_count", 64'(count_o), 64'd1);
      check("push1_stall", 64'(stall_fetch_o), 64'd0);
      drive(1'b1, 32'hB, 32'h04, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'hC, 32'h08, 1'b0, 1'b0);
      step();
      check("push3_count", 64'(count_o), 64'd3);
      check("push3_stall", 64'(stall_fetch_o), 64'd1);
      check("push3_head_pc", 64'(out_pc), 64'h00);
      check("push3_head_instr", 64'(out_instr), 64'hA);

      // Drain in order
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("drain_pc", 64'(out_pc), 64'(4 * i));
         check("drain_instr", 64'(out_instr), 64'(32'hA + i));
         step();
      end
      out_ready = 1'b0;
      check("drained_valid", 64'(out_valid), 64'd0);
      check("drained_instr", 64'(out_instr), 64'h13);
      check("drained_count", 64'(count_o), 64'd0);

      // Fill to four, push a fifth with no pop -> dropped
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(i), 32'h10 + 32'(4 * i), 1'b0, 1'b0);
         step();
      end
      check("full_count", 64'(count_o), 64'd4);
      check("full_stall", 64'(stall_fetch_o), 64'd1);
      check("full_ovf_clear", 64'(overflow_o), 64'd0);
      drive(1'b1, 32'h1FF, 32'h20, 1'b0, 1'b0);
      step();
      check("drop_count", 64'(count_o), 64'd4);
      check("drop_ovf", 64'(overflow_o), 64'd1);
      check("drop_head", 64'(out_pc), 64'h10);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      step();
      check("flush_keeps_ovf", 64'(overflow_o), 64'd1);
      check("flush_count", 64'(count_o), 64'd0);

      // Full with simultaneous pop: fifth accepted, no overflow
      do_reset();
      check("rst2_ovf", 64'(overflow_o), 64'd0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(i), 32'h10 + 32'(4 * i), 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h104, 32'h20, 1'b1, 1'b0);
      step();
      check("full_pp_count", 64'(count_o), 64'd4);
      check("full_pp_ovf", 64'(overflow_o), 64'd0);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("full_pp_order", 64'(out_pc), 64'(32'h14 + 32'(4 * i)));
         check("full_pp_instr", 64'(out_instr), 64'(32'h101 + 32'(i)));
         step();
      end
      check("full_pp_empty", 64'(out_valid), 64'd0);

      // Flush at count 3 with push and pop requested
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(i), 32'h40 + 32'(4 * i), 1'b0, 1'b0);
         step();
      end
      check("pre_flush_count", 64'(count_o), 64'd3);
      drive(1'b1, 32'h3FF, 32'h80, 1'b1, 1'b1);
      step();
      check("flush_count3", 64'(count_o), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_pc", 64'(out_pc), 64'hFFFF_FFFF);
      check("flush_stall", 64'(stall_fetch_o), 64'd0);
      drive(1'b1, 32'h3AA, 32'h90, 1'b0, 1'b0);
      step();
      check("post_flush_head", 64'(out_pc), 64'h90);
      check("post_flush_count", 64'(count_o), 64'd1);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();

      // Streaming: push and pop every cycle, pointers wrap
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h500 + 32'(i), 32'h100 + 32'(4 * i), 1'b1, 1'b0);
         #1;
         if (i > 0) begin
            check("stream_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * (i - 1))));
            check("stream_instr", 64'(out_instr), 64'(32'h500 + 32'(i - 1)));
         end else begin
            check("stream_start_empty", 64'(out_valid), 64'd0);
         end
         step();
         check("stream_count", 64'(count_o), 64'd1);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      #1 check("stream_last_pc", 64'(out_pc), 64'h124);
      step();
      check("stream_end_count", 64'(count_o), 64'd0);

      // Reset mid-operation with count 2 and overflow set
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h600 + 32'(i), 32'h180 + 32'(4 * i), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      step();
      check("pre_rst_count", 64'(count_o), 64'd2);
      check("pre_rst_ovf", 64'(overflow_o), 64'd1);
      reset = 1'b1;
      drive(1'b1, 32'h7FF, 32'h1F0, 1'b1, 1'b1);
      step();
      reset = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      check_reset_state("rst3");
      drive(1'b1, 32'h777, 32'h200, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      check("rst3_push_pc", 64'(out_pc), 64'h200);
      check("rst3_push_instr", 64'(out_instr), 64'h777);
      check("rst3_push_count", 64'(count_o), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
